// File: rtl/test_transmitter_if.sv
// Ethernet header + AXI-stream payload bundle between the traffic generator
// and the eth_axis_tx/MAC path.
interface test_transmitter_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  eth_hdr_valid;
   logic                  eth_hdr_ready;
   logic [47:0]           eth_dest_mac;
   logic [47:0]           eth_src_mac;
   logic [15:0]           eth_type;
   logic [DATA_WIDTH-1:0] eth_payload_axis_tdata;
   logic                  eth_payload_axis_tvalid;
   logic                  eth_payload_axis_tready;
   logic                  eth_payload_axis_tlast;
   logic                  eth_payload_axis_tuser;

   modport master (
      output eth_hdr_valid, eth_dest_mac, eth_src_mac, eth_type,
             eth_payload_axis_tdata, eth_payload_axis_tvalid,
             eth_payload_axis_tlast, eth_payload_axis_tuser,
      input  eth_hdr_ready, eth_payload_axis_tready
   );

   modport slave (
      input  eth_hdr_valid, eth_dest_mac, eth_src_mac, eth_type,
             eth_payload_axis_tdata, eth_payload_axis_tvalid,
             eth_payload_axis_tlast, eth_payload_axis_tuser,
      output eth_hdr_ready, eth_payload_axis_tready
   );
endinterface

// File: rtl/test_transmitter.sv
// Link bring-up traffic generator: back-to-back frames with a fixed header and
// a payload taken from a free-running beat counter that spans frames.
module test_transmitter #(
   parameter int          LENGTH      = 512,
   parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_00,
   parameter logic [47:0] DST_MAC     = 48'h02_00_00_00_00_00,
   parameter logic [15:0] ETH_TYPE    = 16'h88B5,
   parameter int          GAP_CYCLES  = 16,
   parameter int          NUM_FRAMES  = 0,
   parameter int          DATA_WIDTH  = 8,
   parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int          KEEP_WIDTH  = (DATA_WIDTH / 8)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   test_transmitter_if.master m,
   output logic               busy,
   output logic               done,
   output logic [31:0]        frame_count,
   output logic [31:0]        beat_count
);

   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, GAP} state_t;

   localparam logic [15:0] LAST_IDX    = 16'(LENGTH - 1);
   localparam logic [15:0] GAP_LOAD    = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
   localparam logic [31:0] FRAME_LIMIT = 32'(NUM_FRAMES);

   generate
      if (DATA_WIDTH != 8 || KEEP_ENABLE || KEEP_WIDTH != 1) begin : g_bad_width
         $error("test_transmitter supports an 8-bit payload only");
      end
      if (LENGTH < 1 || LENGTH > 65535) begin : g_bad_length
         $error("test_transmitter LENGTH must be 1..65535");
      end
      if (GAP_CYCLES < 0 || GAP_CYCLES > 65536) begin : g_bad_gap
         $error("test_transmitter GAP_CYCLES must be 0..65536");
      end
   endgenerate

   state_t      state, state_n;
   logic [15:0] idx;
   logic [15:0] gap_cnt;
   logic        hdr_fire, pay_fire, last_fire, last_frame;

   // Outputs decode straight from the state register, so reset clears them
   // without waiting for a clock edge.
   assign m.eth_hdr_valid           = (state == HDR);
   assign m.eth_dest_mac            = DST_MAC;
   assign m.eth_src_mac             = LOCAL_MAC;
   assign m.eth_type                = ETH_TYPE;
   assign m.eth_payload_axis_tvalid = (state == PAYLOAD);
   assign m.eth_payload_axis_tdata  = beat_count[DATA_WIDTH-1:0];
   assign m.eth_payload_axis_tlast  = (state == PAYLOAD) && (idx == LAST_IDX);
   assign m.eth_payload_axis_tuser  = 1'b0;
   assign busy                      = (state != IDLE);

   assign hdr_fire   = m.eth_hdr_valid && m.eth_hdr_ready;
   assign pay_fire   = m.eth_payload_axis_tvalid && m.eth_payload_axis_tready;
   assign last_fire  = pay_fire && m.eth_payload_axis_tlast;
   assign last_frame = (FRAME_LIMIT != 32'd0) && (frame_count + 32'd1 == FRAME_LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (enable && !done) state_n = HDR;
         HDR:     if (hdr_fire) state_n = PAYLOAD;
         PAYLOAD: begin
            // The final frame of a limited run skips the gap entirely.
            if (last_fire) begin
               if (last_frame)           state_n = IDLE;
               else if (GAP_CYCLES != 0) state_n = GAP;
               else if (enable)          state_n = HDR;
               else                      state_n = IDLE;
            end
         end
         GAP:     if (gap_cnt == 16'd0) state_n = (enable && !done) ? HDR : IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx         <= '0;
         gap_cnt     <= '0;
         done        <= 1'b0;
         frame_count <= '0;
         beat_count  <= '0;
      end else begin
         if (pay_fire) begin
            beat_count <= beat_count + 32'd1;
            idx        <= m.eth_payload_axis_tlast ? 16'd0 : idx + 16'd1;
         end
         if (last_fire) begin
            frame_count <= frame_count + 32'd1;
            gap_cnt     <= GAP_LOAD;
            if (last_frame) done <= 1'b1;
         end else if (state == GAP && gap_cnt != 16'd0) begin
            gap_cnt <= gap_cnt - 16'd1;
         end
         // Dropping enable while parked rearms a finished run.
         if (state == IDLE && !enable) begin
            done <= 1'b0;
            if (done) frame_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_test_transmitter.sv
// Scoreboard bench: stimulus queues expected header/beat events per instance,
// a forked monitor pops and compares on every handshake.
module tb_test_transmitter;

   localparam logic [47:0] DST   = 48'h02_11_22_33_44_55;
   localparam logic [47:0] SRC   = 48'h02_AA_BB_CC_DD_EE;
   localparam logic [15:0] ETYPE = 16'h88B5;

   typedef struct {
      bit         hdr;
      logic [7:0] d;
      bit         l;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst3 = 1'b1;
   logic [3:0]  en = 4'b0;
   logic [3:0]  busy_w, done_w;
   logic [31:0] fc [4];
   logic [31:0] bc [4];

   int   checks = 0;
   int   errors = 0;
   ev_t  q0[$], q1[$], q2[$], q3[$];
   int   hdr_seen[4], beat_seen[4], last_seen[4], gap_seen[4], idle_cnt[4];
   bit   after_last[4], hstall[4], pstall[4];
   logic [7:0] pd[4];
   logic pl[4];
   bit   rnd_ready = 1'b0;

   always #4 clk = ~clk;

   test_transmitter_if #(.DATA_WIDTH(8)) if0 ();
   test_transmitter_if #(.DATA_WIDTH(8)) if1 ();
   test_transmitter_if #(.DATA_WIDTH(8)) if2 ();
   test_transmitter_if #(.DATA_WIDTH(8)) if3 ();

   test_transmitter #(.LENGTH(4), .GAP_CYCLES(2), .NUM_FRAMES(2),
                      .LOCAL_MAC(SRC), .DST_MAC(DST), .ETH_TYPE(ETYPE)) u0 (
      .clk(clk), .rst(rst), .enable(en[0]), .m(if0.master), .busy(busy_w[0]),
      .done(done_w[0]), .frame_count(fc[0]), .beat_count(bc[0]));

   test_transmitter #(.LENGTH(300), .GAP_CYCLES(16), .NUM_FRAMES(0),
                      .LOCAL_MAC(SRC), .DST_MAC(DST), .ETH_TYPE(ETYPE)) u1 (
      .clk(clk), .rst(rst), .enable(en[1]), .m(if1.master), .busy(busy_w[1]),
      .done(done_w[1]), .frame_count(fc[1]), .beat_count(bc[1]));

   test_transmitter #(.LENGTH(1), .GAP_CYCLES(0), .NUM_FRAMES(0),
                      .LOCAL_MAC(SRC), .DST_MAC(DST), .ETH_TYPE(ETYPE)) u2 (
      .clk(clk), .rst(rst), .enable(en[2]), .m(if2.master), .busy(busy_w[2]),
      .done(done_w[2]), .frame_count(fc[2]), .beat_count(bc[2]));

   test_transmitter #(.LENGTH(8), .GAP_CYCLES(3), .NUM_FRAMES(3),
                      .LOCAL_MAC(SRC), .DST_MAC(DST), .ETH_TYPE(ETYPE)) u3 (
      .clk(clk), .rst(rst3), .enable(en[3]), .m(if3.master), .busy(busy_w[3]),
      .done(done_w[3]), .frame_count(fc[3]), .beat_count(bc[3]));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push_ev(input int i, input ev_t e);
      case (i)
         0: q0.push_back(e);
         1: q1.push_back(e);
         2: q2.push_back(e);
         default: q3.push_back(e);
      endcase
   endtask

   // One header followed by len beats whose data continues from start.
   task automatic push_frame(input int i, input int start, input int len);
      ev_t e;
      for (int k = 0; k <= len; k++) begin
         e.hdr = (k == 0);
         e.d   = (k == 0) ? 8'h00 : 8'(start + k - 1);
         e.l   = (k == len);
         push_ev(i, e);
      end
   endtask

   task automatic pop(input int i, output ev_t e, output bit ok);
      ok = 1'b0; e.hdr = 1'b0; e.d = 8'h00; e.l = 1'b0;
      case (i)
         0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
         2: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
         default: if (q3.size() > 0) begin e = q3.pop_front(); ok = 1'b1; end
      endcase
   endtask

   function automatic int qsize(input int i);
      case (i)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         default: return q3.size();
      endcase
   endfunction

   task automatic mon_ev(input int i, input logic hv, input logic hr, input logic tv,
                         input logic tr, input logic tl, input logic tu, input logic [7:0] td,
                         input logic [47:0] dm, input logic [47:0] sm, input logic [15:0] et);
      ev_t e;
      bit  ok;
      if (hstall[i]) chk($sformatf("u%0d hdr_valid hold", i), hv, 1);
      if (pstall[i]) begin
         chk($sformatf("u%0d tvalid hold", i), tv, 1);
         chk($sformatf("u%0d tdata hold", i), td, pd[i]);
         chk($sformatf("u%0d tlast hold", i), tl, pl[i]);
      end
      hstall[i] = hv && !hr;
      pstall[i] = tv && !tr;
      pd[i] = td;
      pl[i] = tl;
      if (hv || tv) chk($sformatf("u%0d hdr/payload overlap", i), hv && tv, 0);
      if (hv && after_last[i]) begin
         gap_seen[i] = idle_cnt[i];
         after_last[i] = 1'b0;
      end else if (after_last[i] && !tv) begin
         idle_cnt[i]++;
      end
      if (hv && hr) begin
         pop(i, e, ok);
         hdr_seen[i]++;
         chk($sformatf("u%0d header expected", i), ok, 1);
         if (ok) begin
            chk($sformatf("u%0d event kind hdr", i), e.hdr, 1);
            chk($sformatf("u%0d dest_mac", i), dm, DST);
            chk($sformatf("u%0d src_mac", i), sm, SRC);
            chk($sformatf("u%0d eth_type", i), et, ETYPE);
         end
      end
      if (tv && tr) begin
         pop(i, e, ok);
         beat_seen[i]++;
         chk($sformatf("u%0d beat expected", i), ok, 1);
         if (ok) begin
            chk($sformatf("u%0d event kind beat", i), e.hdr, 0);
            chk($sformatf("u%0d tdata beat %0d", i, beat_seen[i]), td, e.d);
            chk($sformatf("u%0d tlast beat %0d", i, beat_seen[i]), tl, e.l);
         end
         chk($sformatf("u%0d tuser", i), tu, 0);
         if (tl) begin
            last_seen[i]++;
            after_last[i] = 1'b1;
            idle_cnt[i] = 0;
         end
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         mon_ev(0, if0.eth_hdr_valid, if0.eth_hdr_ready, if0.eth_payload_axis_tvalid,
                if0.eth_payload_axis_tready, if0.eth_payload_axis_tlast, if0.eth_payload_axis_tuser,
                if0.eth_payload_axis_tdata, if0.eth_dest_mac, if0.eth_src_mac, if0.eth_type);
         mon_ev(1, if1.eth_hdr_valid, if1.eth_hdr_ready, if1.eth_payload_axis_tvalid,
                if1.eth_payload_axis_tready, if1.eth_payload_axis_tlast, if1.eth_payload_axis_tuser,
                if1.eth_payload_axis_tdata, if1.eth_dest_mac, if1.eth_src_mac, if1.eth_type);
         mon_ev(2, if2.eth_hdr_valid, if2.eth_hdr_ready, if2.eth_payload_axis_tvalid,
                if2.eth_payload_axis_tready, if2.eth_payload_axis_tlast, if2.eth_payload_axis_tuser,
                if2.eth_payload_axis_tdata, if2.eth_dest_mac, if2.eth_src_mac, if2.eth_type);
         mon_ev(3, if3.eth_hdr_valid, if3.eth_hdr_ready, if3.eth_payload_axis_tvalid,
                if3.eth_payload_axis_tready, if3.eth_payload_axis_tlast, if3.eth_payload_axis_tuser,
                if3.eth_payload_axis_tdata, if3.eth_dest_mac, if3.eth_src_mac, if3.eth_type);
      end
   endtask

   task automatic drive_ready();
      forever begin
         @(posedge clk);
         #1;
         if1.eth_hdr_ready           = rnd_ready ? ($urandom_range(0, 4) > 1) : 1'b1;
         if1.eth_payload_axis_tready = rnd_ready ? ($urandom_range(0, 4) > 1) : 1'b1;
      end
   endtask

   function automatic bit cond(input int kind, input int i, input int tgt);
      case (kind)
         0: return done_w[i];
         1: return !busy_w[i];
         2: return hdr_seen[i] >= tgt;
         3: return beat_seen[i] >= tgt;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input string name, input int kind, input int i, input int tgt);
      int n = 0;
      while (!cond(kind, i, tgt) && n < 5000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({name, " timeout"}, cond(kind, i, tgt), 1);
   endtask

   initial begin
      if0.eth_hdr_ready = 1'b1; if0.eth_payload_axis_tready = 1'b1;
      if1.eth_hdr_ready = 1'b1; if1.eth_payload_axis_tready = 1'b1;
      if2.eth_hdr_ready = 1'b1; if2.eth_payload_axis_tready = 1'b1;
      if3.eth_hdr_ready = 1'b1; if3.eth_payload_axis_tready = 1'b1;
      fork
         monitor();
         drive_ready();
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk("reset hdr_valid", if0.eth_hdr_valid, 0);
      chk("reset tvalid", if0.eth_payload_axis_tvalid, 0);
      chk("reset tlast", if0.eth_payload_axis_tlast, 0);
      chk("reset busy", busy_w[0], 0);
      chk("reset done", done_w[0], 0);
      chk("reset frame_count", fc[0], 0);
      chk("reset beat_count", bc[0], 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rst3 = 1'b0;

      // Two limited frames, gap of 2.
      push_frame(0, 0, 4);
      push_frame(0, 4, 4);
      en[0] = 1'b1;
      wait_for("u0 done", 0, 0, 0);
      chk("u0 frame_count", fc[0], 2);
      chk("u0 beat_count", bc[0], 8);
      chk("u0 gap cycles", gap_seen[0], 2);
      chk("u0 busy after done", busy_w[0], 0);
      repeat (10) @(negedge clk);
      #1;
      chk("u0 queue drained", qsize(0), 0);
      en[0] = 1'b0;

      // Long frames with random backpressure, enable dropped in frame 2.
      rnd_ready = 1'b1;
      push_frame(1, 0, 300);
      push_frame(1, 300, 300);
      en[1] = 1'b1;
      wait_for("u1 second header", 2, 1, 2);
      @(posedge clk);
      #1;
      en[1] = 1'b0;
      wait_for("u1 idle", 1, 1, 0);
      repeat (20) @(negedge clk);
      #1;
      chk("u1 frame_count", fc[1], 2);
      chk("u1 beat_count", bc[1], 600);
      chk("u1 tlast count", last_seen[1], 2);
      chk("u1 queue drained", qsize(1), 0);
      rnd_ready = 1'b0;

      // Single-beat frames, no gap.
      for (int k = 0; k < 5; k++) push_frame(2, k, 1);
      en[2] = 1'b1;
      wait_for("u2 fifth header", 2, 2, 5);
      @(posedge clk);
      #1;
      en[2] = 1'b0;
      wait_for("u2 idle", 1, 2, 0);
      repeat (5) @(negedge clk);
      #1;
      chk("u2 frame_count", fc[2], 5);
      chk("u2 beat_count", bc[2], 5);
      chk("u2 queue drained", qsize(2), 0);

      // Enable dropped on the 2nd beat: frame completes, nothing follows.
      push_frame(3, 0, 8);
      en[3] = 1'b1;
      wait_for("u3 beat 2", 3, 3, 2);
      en[3] = 1'b0;
      wait_for("u3 idle", 1, 3, 0);
      repeat (20) @(negedge clk);
      #1;
      chk("u3 frame_count after stop", fc[3], 1);
      chk("u3 beat_count after stop", bc[3], 8);
      chk("u3 headers after stop", hdr_seen[3], 1);
      chk("u3 queue drained after stop", qsize(3), 0);

      // Asynchronous reset mid-payload.
      push_frame(3, 8, 8);
      en[3] = 1'b1;
      wait_for("u3 beat 10", 3, 3, 10);
      #1;
      rst3 = 1'b1;
      #1;
      chk("async rst hdr_valid", if3.eth_hdr_valid, 0);
      chk("async rst tvalid", if3.eth_payload_axis_tvalid, 0);
      chk("async rst busy", busy_w[3], 0);
      chk("async rst frame_count", fc[3], 0);
      chk("async rst beat_count", bc[3], 0);
      q3.delete();
      push_frame(3, 0, 8);
      push_frame(3, 8, 8);
      push_frame(3, 16, 8);
      @(posedge clk);
      #1;
      rst3 = 1'b0;

      // Three-frame limit, hold, then rearm.
      wait_for("u3 done", 0, 3, 0);
      chk("u3 frame_count at done", fc[3], 3);
      chk("u3 beat_count at done", bc[3], 24);
      repeat (30) @(negedge clk);
      #1;
      chk("u3 headers while held", hdr_seen[3], 5);
      chk("u3 done sticky", done_w[3], 1);
      chk("u3 queue drained at done", qsize(3), 0);
      en[3] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("u3 done cleared", done_w[3], 0);
      chk("u3 frame_count rearm", fc[3], 0);
      chk("u3 beat_count kept", bc[3], 24);
      push_frame(3, 24, 8);
      push_frame(3, 32, 8);
      push_frame(3, 40, 8);
      en[3] = 1'b1;
      wait_for("u3 done again", 0, 3, 0);
      chk("u3 frame_count second run", fc[3], 3);
      chk("u3 beat_count second run", bc[3], 48);
      repeat (5) @(negedge clk);
      #1;
      chk("u3 queue drained second run", qsize(3), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
